dmem_responder: RTL and testbench

Data-memory responder for the multicycle RISC-V core: the memory end of the core's load/store interface. It accepts one request at a time over a Req/Ack handshake and serves byte, half, word and double accesses to a 64-bit-wide internal RAM. It inserts a configurable number of wait states and reports misaligned or out-of-range accesses so the control unit can raise an exception.

---
 rtl/dmem_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states; optional fault checks under DMEM_FAULT_EN
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [63:0] Addr,
  input  logic [63:0] WData,
  output logic        Ack,
  output logic [63:0] RData,
  output logic        Busy,
  output logic        Fault,
  output logic [1:0]  FaultCause
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   size_mask = 3'b000;
      2'b01:   size_mask = 3'b001;
      2'b10:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size, before shifting to the offset.
  function automatic logic [7:0] size_lanes(input logic [1:0] s);
    case (s)
      2'b00:   size_lanes = 8'h01;
      2'b01:   size_lanes = 8'h03;
      2'b10:   size_lanes = 8'h0F;
      default: size_lanes = 8'hFF;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        fpend_q, fpend_d;
  logic [1:0]  cpend_q, cpend_d;
  logic        ack_q, ack_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [63:0] rdata_q, rdata_d;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic        chk_fault;
  logic [1:0]  chk_cause;
  logic [63:0] addr_in;
  logic        cur_wr, cur_uns;
  logic [1:0]  cur_size;
  logic [63:0] cur_addr, cur_wdata;
  logic [AW-1:0] idx;
  logic [2:0]  off;
  logic [63:0] word, shifted, load_val, wsh;
  logic [7:0]  bmask;
  logic        commit;

  // Request checks and address shaping applied at acceptance time in IDLE.
  always_comb begin
`ifdef DMEM_FAULT_EN
    logic mis, oor;
    mis       = |(Addr[2:0] & size_mask(Size));
    oor       = (Addr[63:3] >= 61'(DEPTH_WORDS));
    chk_fault = mis | oor;
    chk_cause = mis ? 2'b01 : (oor ? 2'b10 : 2'b00);
    addr_in   = Addr;
`else
    chk_fault = 1'b0;
    chk_cause = 2'b00;
    addr_in   = {Addr[63:3], Addr[2:0] & ~size_mask(Size)};
`endif
  end

  // Datapath: in IDLE the live inputs drive a zero-wait commit, otherwise the latched request.
  always_comb begin
    logic [60:0] widx;
    cur_wr    = (state_q == S_IDLE) ? Wr       : wr_q;
    cur_size  = (state_q == S_IDLE) ? Size     : size_q;
    cur_uns   = (state_q == S_IDLE) ? Unsigned : uns_q;
    cur_addr  = (state_q == S_IDLE) ? addr_in  : addr_q;
    cur_wdata = (state_q == S_IDLE) ? WData    : wdata_q;
`ifdef DMEM_FAULT_EN
    widx = cur_addr[63:3];
`else
    widx = cur_addr[63:3] % 61'(DEPTH_WORDS);
`endif
    idx     = widx[AW-1:0];
    off     = cur_addr[2:0];
    word    = mem_q[idx];
    shifted = word >> {off, 3'b000};
    case (cur_size)
      2'b00:   load_val = {{56{~cur_uns & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{48{~cur_uns & shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = {{32{~cur_uns & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
    wsh   = cur_wdata << {off, 3'b000};
    bmask = size_lanes(cur_size) << off;
  end

  // Next-state logic for the IDLE/WAIT/RESP handshake FSM and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fpend_d = fpend_q;
    cpend_d = cpend_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    fault_d = 1'b0;
    cause_d = 2'b00;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          wr_d    = Wr;
          size_d  = Size;
          uns_d   = Unsigned;
          addr_d  = addr_in;
          wdata_d = WData;
          fpend_d = chk_fault;
          cpend_d = chk_cause;
          if (chk_fault) begin
            rdata_d = 64'd0;
            state_d = S_RESP;
          end else if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = WS - 4'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        ack_d   = 1'b1;
        fault_d = fpend_q;
        cause_d = cpend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) rdata_d = cur_wr ? 64'd0 : load_val;
  end

  // Control and output registers; the RAM itself is deliberately left out of reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      fpend_q <= 1'b0;
      cpend_q <= 2'b00;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fpend_q <= fpend_d;
      cpend_q <= cpend_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-lane store into the RAM word on the commit edge.
  always_ff @(posedge Clk) begin
    if (commit && cur_wr) begin
      for (int i = 0; i < 8; i++) begin
        if (bmask[i]) mem_q[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  assign Ack        = ack_q;
  assign RData      = rdata_q;
  assign Busy       = (state_q != S_IDLE);
  assign Fault      = fault_q;
  assign FaultCause = cause_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req = 1'b0;
  logic        Wr = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        Unsigned = 1'b0;
  logic [63:0] Addr = 64'd0;
  logic [63:0] WData = 64'd0;
  logic        Ack, Busy, Fault;
  logic [63:0] RData;
  logic [1:0]  FaultCause;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Size(Size), .Unsigned(Unsigned),
    .Addr(Addr), .WData(WData), .Ack(Ack), .RData(RData), .Busy(Busy),
    .Fault(Fault), .FaultCause(FaultCause)
  );

  always #5 Clk = ~Clk;

  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [63:0] wd, output int lat,
                        output logic [63:0] rd, output logic f, output logic [1:0] fc);
    @(negedge Clk);
    Req = 1'b1; Wr = wr; Size = sz; Unsigned = uns; Addr = a; WData = wd;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0; Addr = 64'hDEAD_BEEF_0000_0005; WData = '1;
    lat = -1; rd = 64'd0; f = 1'b0; fc = 2'b00;
    if (Ack) begin
      lat = 0; rd = RData; f = Fault; fc = FaultCause;
    end else begin
      for (int n = 1; n <= 20; n++) begin
        @(posedge Clk);
        @(negedge Clk);
        if (Ack) begin
          lat = n; rd = RData; f = Fault; fc = FaultCause;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", Ack); end
    checks++; if (RData !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", RData); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", Fault); end
    checks++; if (FaultCause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b want 00", FaultCause); end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_double;
    int lat; logic [63:0] rd; logic f; logic [1:0] fc;
    access(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, lat, rd, f, fc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL st_dbl_latency got %0d want 3", lat); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL st_dbl_rdata got %h want 0", rd); end
    access(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, lat, rd, f, fc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ld_dbl_latency got %0d want 3", lat); end
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL ld_dbl_rdata got %h want 1122334455667788", rd); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL ld_dbl_fault got %b want 0", f); end
  endtask

  task automatic test_byte;
    int lat; logic [63:0] rd; logic f; logic [1:0] fc;
    access(1'b1, 2'b00, 1'b0, 64'h13, 64'h0000_0000_1234_56AB, lat, rd, f, fc);
    access(1'b0, 2'b00, 1'b0, 64'h13, 64'd0, lat, rd, f, fc);
    checks++; if (rd !== 64'hFFFFFFFFFFFFFFAB) begin errors++; $display("FAIL ld_byte_signed got %h want ffffffffffffffab", rd); end
    access(1'b0, 2'b00, 1'b1, 64'h13, 64'd0, lat, rd, f, fc);
    checks++; if (rd !== 64'h00000000000000AB) begin errors++; $display("FAIL ld_byte_unsigned got %h want 00000000000000ab", rd); end
    access(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, lat, rd, f, fc);
    checks++; if (rd !== 64'h11223344AB667788) begin errors++; $display("FAIL ld_dbl_after_byte got %h want 11223344ab667788", rd); end
  endtask

  task automatic test_misaligned;
    int lat; logic [63:0] rd; logic f; logic [1:0] fc;
    access(1'b0, 2'b10, 1'b0, 64'h12, 64'd0, lat, rd, f, fc);
`ifdef DMEM_FAULT_EN
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency got %0d want 1", lat); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL mis_fault got %b want 1", f); end
    checks++; if (fc !== 2'b01) begin errors++; $display("FAIL mis_cause got %b want 01", fc); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL mis_rdata got %h want 0", rd); end
`else
    checks++; if (lat !== 3) begin errors++; $display("FAIL mis_latency got %0d want 3", lat); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL mis_fault got %b want 0", f); end
    checks++; if (rd !== 64'hFFFFFFFFAB667788) begin errors++; $display("FAIL mis_rdata got %h want ffffffffab667788", rd); end
`endif
  endtask

  task automatic test_range;
    int lat; logic [63:0] rd; logic f; logic [1:0] fc;
    access(1'b1, 2'b11, 1'b0, 64'h0, 64'hCAFEBABE00000001, lat, rd, f, fc);
    access(1'b1, 2'b11, 1'b0, 64'h800, 64'h5555666677778888, lat, rd, f, fc);
`ifdef DMEM_FAULT_EN
    exp0 = 64'hCAFEBABE00000001;
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_latency got %0d want 1", lat); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL oor_fault got %b want 1", f); end
    checks++; if (fc !== 2'b10) begin errors++; $display("FAIL oor_cause got %b want 10", fc); end
`else
    exp0 = 64'h5555666677778888;
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL wrap_fault got %b want 0", f); end
`endif
    access(1'b0, 2'b11, 1'b0, 64'h0, 64'd0, lat, rd, f, fc);
    checks++; if (rd !== exp0) begin errors++; $display("FAIL ld_word0 got %h want %h", rd, exp0); end
  endtask

  task automatic test_reset_abort;
    int lat; logic [63:0] rd; logic f; logic [1:0] fc;
    access(1'b1, 2'b01, 1'b0, 64'h20, 64'h8234, lat, rd, f, fc);
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b1; Size = 2'b01; Unsigned = 1'b0; Addr = 64'h20; WData = 64'hFFFF;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_busy_wait got %b want 1", Busy); end
    Reset = 1'b0;
    #1;
    checks++; if ({Ack, Busy, Fault, FaultCause, RData} !== 69'd0) begin
      errors++; $display("FAIL abort_outputs got %b %b %b %b %h want all 0", Ack, Busy, Fault, FaultCause, RData);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      checks++; if (Ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack got %b want 0", Ack); end
    end
    @(negedge Clk);
    Reset = 1'b1;
    access(1'b0, 2'b01, 1'b0, 64'h20, 64'd0, lat, rd, f, fc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL abort_reload_latency got %0d want 3", lat); end
    checks++; if (rd !== 64'hFFFFFFFFFFFF8234) begin errors++; $display("FAIL abort_reload got %h want ffffffffffff8234", rd); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_busy;
    logic [7:0] exp_ack;
    exp_busy = 8'b0111_0111;
    exp_ack  = 8'b1000_1000;
    @(negedge Clk);
    Req = 1'b1; Wr = 1'b0; Size = 2'b11; Unsigned = 1'b0; Addr = 64'h10;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      checks++; if (Busy !== exp_busy[i]) begin errors++; $display("FAIL b2b_busy[%0d] got %b want %b", i, Busy, exp_busy[i]); end
      checks++; if (Ack !== exp_ack[i]) begin errors++; $display("FAIL b2b_ack[%0d] got %b want %b", i, Ack, exp_ack[i]); end
      if (i == 0) Addr = 64'h0;
      if (i == 3) begin
        checks++; if (RData !== 64'h11223344AB667788) begin errors++; $display("FAIL b2b_first got %h want 11223344ab667788", RData); end
      end
      if (i == 4) Req = 1'b0;
      if (i == 7) begin
        checks++; if (RData !== exp0) begin errors++; $display("FAIL b2b_second got %h want %h", RData, exp0); end
      end
    end
  endtask

  initial begin
    exp0 = 64'd0;
    #12;
    test_reset();
    test_double();
    test_byte();
    test_misaligned();
    test_range();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
